// File: rtl/prbs_multi_seq.sv
// prbs_multi_seq: multi-lane PRBS link self-test sequencer.
//   Waits for transceiver bring-up (alldone), enables TX then RX PRBS, injects
//   errors for a fixed time and proves every lane's checker saw them, waits for
//   the checkers to drain and stay clean while their counters are held in
//   reset, then hands the link to software (ACTIVE) or parks in FAIL.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   alldone               transceiver reset/PLL sequencing complete
//   restart               synchronous request to rerun the test
//   rx_prbs_err[N_CH]     per-lane checker error flag
//   checker_status[N_CH]  per-lane checker not-clean flag
//   prbscntreset_ext      software counter reset (ACTIVE only)
//   error_inject_ext      software error inject (ACTIVE only)
//   tx/rx_prbs_mode       PRBS mode for all lanes
//   prbscntreset          checker counter reset
//   error_inject          TX error inject
//   inject_seen[N_CH]     sticky per-lane "error observed during INJECT"
//   err_count             per-lane saturating counts, lane i at [i*ERR_CNT_W +: ERR_CNT_W]
//   state_dbg             current state encoding
//   test_done/pass/fail   verdict
module prbs_multi_seq #(
  parameter int          N_CH              = 4,
  parameter logic [2:0]  PRBS_MODE         = 3'b100,
  parameter logic [31:0] INJECT_CYCLES     = 32'd1000000000,
  parameter logic [31:0] CLEAR_HOLD_CYCLES = 32'd512,
  parameter logic [31:0] TIMEOUT_CYCLES    = 32'd1048576,
  parameter int          ERR_CNT_W         = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alldone,
  input  logic                      restart,
  input  logic [N_CH-1:0]           rx_prbs_err,
  input  logic [N_CH-1:0]           checker_status,
  input  logic                      prbscntreset_ext,
  input  logic                      error_inject_ext,
  output logic [2:0]                tx_prbs_mode,
  output logic [2:0]                rx_prbs_mode,
  output logic                      prbscntreset,
  output logic                      error_inject,
  output logic [N_CH-1:0]           inject_seen,
  output logic [N_CH*ERR_CNT_W-1:0] err_count,
  output logic [3:0]                state_dbg,
  output logic                      test_done,
  output logic                      test_pass,
  output logic                      test_fail
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WAIT_DONE = 4'd1,
    S_TX_EN     = 4'd2,
    S_RX_EN     = 4'd3,
    S_INJECT    = 4'd4,
    S_DRAIN     = 4'd5,
    S_CLEAR     = 4'd6,
    S_ACTIVE    = 4'd7,
    S_FAIL      = 4'd8
  } state_t;

  state_t                    state_r, state_s;
  logic [31:0]               phase_cnt_r;
  logic [31:0]               hold_cnt_r, hold_cnt_s, hold_inc_s;
  logic [N_CH-1:0]           inject_seen_r;
  logic [N_CH*ERR_CNT_W-1:0] err_count_r;
  logic                      restart_s, err_any_s, clean_s, hold_done_s;
  logic                      inject_end_s, timeout_s;

  assign restart_s    = restart && (state_r != S_IDLE);
  assign err_any_s    = |rx_prbs_err;
  assign clean_s      = !err_any_s && !(|checker_status);
  // hold_cnt saturates at the target; the hold completes on the cycle the
  // count reaches CLEAR_HOLD_CYCLES, so CLEAR lasts exactly that many clean cycles.
  assign hold_inc_s   = (hold_cnt_r >= CLEAR_HOLD_CYCLES) ? hold_cnt_r : hold_cnt_r + 32'd1;
  assign hold_done_s  = clean_s && (hold_inc_s >= CLEAR_HOLD_CYCLES);
  assign inject_end_s = (phase_cnt_r == INJECT_CYCLES - 32'd1);
  assign timeout_s    = (phase_cnt_r == TIMEOUT_CYCLES - 32'd1);

  // Next-state and next hold count; restart overrides every other transition.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    if (restart_s) begin
      state_s    = S_IDLE;
      hold_cnt_s = 32'd0;
    end else begin
      case (state_r)
        S_IDLE:      state_s = S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (alldone) state_s = S_TX_EN;
          else         state_s = S_WAIT_DONE;
        end
        S_TX_EN:     state_s = S_RX_EN;
        S_RX_EN:     state_s = S_INJECT;
        S_INJECT: begin
          if (inject_end_s) state_s = S_DRAIN;
          else              state_s = S_INJECT;
        end
        S_DRAIN: begin
          if (!err_any_s)     state_s = S_CLEAR;
          else if (timeout_s) state_s = S_FAIL;
          else                state_s = S_DRAIN;
        end
        S_CLEAR: begin
          if (clean_s) hold_cnt_s = hold_inc_s;
          else         hold_cnt_s = 32'd0;
          // A completed hold beats a timeout landing on the same cycle.
          if (hold_done_s) begin
            if (&inject_seen_r) state_s = S_ACTIVE;
            else                state_s = S_FAIL;
          end else if (timeout_s) begin
            state_s = S_FAIL;
          end else begin
            state_s = S_CLEAR;
          end
        end
        S_ACTIVE:    state_s = S_ACTIVE;
        S_FAIL:      state_s = S_FAIL;
        default:     state_s = S_IDLE;
      endcase
      if (state_s != state_r) hold_cnt_s = 32'd0;
      else                    hold_cnt_s = hold_cnt_s;
    end
  end

  // State, phase and hold counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      phase_cnt_r <= 32'd0;
      hold_cnt_r  <= 32'd0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      if (state_s != state_r) phase_cnt_r <= 32'd0;
      else                    phase_cnt_r <= phase_cnt_r + 32'd1;
    end
  end

  // Sticky per-lane injection evidence; only flags seen during INJECT count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inject_seen_r <= {N_CH{1'b0}};
    end else if (restart_s) begin
      inject_seen_r <= inject_seen_r;
    end else if (state_r == S_RX_EN) begin
      inject_seen_r <= {N_CH{1'b0}};
    end else if (state_r == S_INJECT) begin
      inject_seen_r <= inject_seen_r | rx_prbs_err;
    end else begin
      inject_seen_r <= inject_seen_r;
    end
  end

  // Per-lane saturating error counters in ACTIVE; software clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_r <= {(N_CH*ERR_CNT_W){1'b0}};
    end else if (restart_s) begin
      err_count_r <= {(N_CH*ERR_CNT_W){1'b0}};
    end else if (state_r == S_ACTIVE) begin
      for (int i = 0; i < N_CH; i++) begin
        if (prbscntreset_ext) begin
          err_count_r[i*ERR_CNT_W +: ERR_CNT_W] <= {ERR_CNT_W{1'b0}};
        end else if (rx_prbs_err[i] &&
                     (err_count_r[i*ERR_CNT_W +: ERR_CNT_W] != {ERR_CNT_W{1'b1}})) begin
          err_count_r[i*ERR_CNT_W +: ERR_CNT_W] <=
            err_count_r[i*ERR_CNT_W +: ERR_CNT_W] + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
          err_count_r[i*ERR_CNT_W +: ERR_CNT_W] <= err_count_r[i*ERR_CNT_W +: ERR_CNT_W];
        end
      end
    end else begin
      err_count_r <= err_count_r;
    end
  end

  // Output decode from the registered state; ext inputs pass through in ACTIVE only.
  always_comb begin
    tx_prbs_mode = 3'b000;
    rx_prbs_mode = 3'b000;
    prbscntreset = 1'b0;
    error_inject = 1'b0;
    test_done    = 1'b0;
    test_pass    = 1'b0;
    test_fail    = 1'b0;
    case (state_r)
      S_TX_EN, S_RX_EN: tx_prbs_mode = PRBS_MODE;
      S_INJECT: begin
        tx_prbs_mode = PRBS_MODE;
        rx_prbs_mode = PRBS_MODE;
        error_inject = 1'b1;
      end
      S_DRAIN: begin
        tx_prbs_mode = PRBS_MODE;
        rx_prbs_mode = PRBS_MODE;
      end
      S_CLEAR: begin
        tx_prbs_mode = PRBS_MODE;
        rx_prbs_mode = PRBS_MODE;
        prbscntreset = 1'b1;
      end
      S_ACTIVE: begin
        tx_prbs_mode = PRBS_MODE;
        rx_prbs_mode = PRBS_MODE;
        prbscntreset = prbscntreset_ext;
        error_inject = error_inject_ext;
        test_done    = 1'b1;
        test_pass    = 1'b1;
      end
      S_FAIL: begin
        test_done = 1'b1;
        test_fail = 1'b1;
      end
      default: begin
        tx_prbs_mode = 3'b000;
      end
    endcase
  end

  assign inject_seen = inject_seen_r;
  assign err_count   = err_count_r;
  assign state_dbg   = state_r;

endmodule
